// File: rtl/jtkunio_pal_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jtkunio_pal_arb: time-slot arbiter sharing the 512x8 palette RAM between
// the video colour lookup and posted/read CPU accesses.        rev 1.0
// ----------------------------------------------------------------------------
module jtkunio_pal_arb #(
  parameter AW      = 9,
  parameter SIMFILE = "pal.bin"
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          vid_blank,
  input  logic [7:0]    vid_a,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic          wbuf_full,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_q
);

  typedef enum logic [1:0] {
    SLOT_VLO  = 2'd0,
    SLOT_VHI  = 2'd1,
    SLOT_CPU2 = 2'd2,
    SLOT_CPU3 = 2'd3
  } slot_t;

  slot_t          slot_q, slot_d, slot;
  logic [7:0]     va_q, va_d;
  logic           blank_q, blank_d;
  logic           vlo_pend_q, vlo_pend_d;
  logic           vhi_pend_q, vhi_pend_d;
  logic [3:0]     nr_q, nr_d, ng_q, ng_d, nb_q, nb_d;
  logic [11:0]    rgb_q, rgb_d;
  logic           wbuf_full_q, wbuf_full_d;
  logic [AW-1:0]  wb_addr_q, wb_addr_d;
  logic [7:0]     wb_din_q, wb_din_d;
  logic           ack_q, ack_d;
  logic           rd_pend_q, rd_pend_d;
  logic [7:0]     dout_q, dout_d;

  logic           vid_lo, vid_hi, cpu_slot, drain, wr_acc, rd_iss;
  logic           unused_simfile;

  assign unused_simfile = ^SIMFILE;

  always_comb begin
    // the pixel enable itself is slot 0, so the low read goes out immediately
    slot = pxl_cen ? SLOT_VLO : slot_q;
    case (slot)
      SLOT_VLO: slot_d = SLOT_VHI;
      SLOT_VHI: slot_d = SLOT_CPU2;
      default:  slot_d = SLOT_CPU3;
    endcase

    vid_lo   = (slot == SLOT_VLO) && !vid_blank;
    vid_hi   = (slot == SLOT_VHI) && !blank_q;
    cpu_slot = !(vid_lo || vid_hi);
    drain    = wbuf_full_q && cpu_slot;
    // the cycle carrying an ack never starts a new transaction
    wr_acc   = cpu_req && cpu_we && !ack_q && (!wbuf_full_q || drain);
    rd_iss   = cpu_req && !cpu_we && !ack_q && cpu_slot && !wbuf_full_q;

    va_d       = pxl_cen ? vid_a : va_q;
    blank_d    = pxl_cen ? vid_blank : blank_q;
    vlo_pend_d = vid_lo;
    vhi_pend_d = vid_hi;
    nb_d       = vlo_pend_q ? ram_q[3:0] : nb_q;
    {ng_d, nr_d} = vhi_pend_q ? ram_q : {ng_q, nr_q};
    rgb_d      = rgb_q;
    if (pxl_cen) rgb_d = blank_q ? 12'd0 : {nr_q, ng_q, nb_q};

    wbuf_full_d = wr_acc || (wbuf_full_q && !drain);
    wb_addr_d   = wr_acc ? cpu_addr : wb_addr_q;
    wb_din_d    = wr_acc ? cpu_din  : wb_din_q;
    ack_d       = wr_acc || rd_iss;
    rd_pend_d   = rd_iss;
    dout_d      = rd_pend_q ? ram_q : dout_q;

    ram_addr = '0;
    ram_we   = 1'b0;
    if (vid_lo) begin
      ram_addr = AW'({1'b0, vid_a});
    end else if (vid_hi) begin
      ram_addr = AW'({1'b1, va_q});
    end else if (drain) begin
      ram_addr = wb_addr_q;
      ram_we   = 1'b1;
    end else if (rd_iss) begin
      ram_addr = cpu_addr;
    end
    if (!rst_n) begin
      ram_addr = '0;
      ram_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= SLOT_CPU3;
      va_q        <= 8'd0;
      blank_q     <= 1'b0;
      vlo_pend_q  <= 1'b0;
      vhi_pend_q  <= 1'b0;
      nr_q        <= 4'd0;
      ng_q        <= 4'd0;
      nb_q        <= 4'd0;
      rgb_q       <= 12'd0;
      wbuf_full_q <= 1'b0;
      wb_addr_q   <= '0;
      wb_din_q    <= 8'd0;
      ack_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      dout_q      <= 8'd0;
    end else begin
      slot_q      <= slot_d;
      va_q        <= va_d;
      blank_q     <= blank_d;
      vlo_pend_q  <= vlo_pend_d;
      vhi_pend_q  <= vhi_pend_d;
      nr_q        <= nr_d;
      ng_q        <= ng_d;
      nb_q        <= nb_d;
      rgb_q       <= rgb_d;
      wbuf_full_q <= wbuf_full_d;
      wb_addr_q   <= wb_addr_d;
      wb_din_q    <= wb_din_d;
      ack_q       <= ack_d;
      rd_pend_q   <= rd_pend_d;
      dout_q      <= dout_d;
    end
  end

  // read data bypasses the hold register so it is valid alongside the ack
  assign cpu_dout  = dout_d;
  assign cpu_ack   = ack_q;
  assign wbuf_full = wbuf_full_q;
  assign ram_din   = wb_din_q;
  assign {red, green, blue} = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_jtkunio_pal_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_jtkunio_pal_arb: self-checking bench for the palette RAM arbiter. rev 1.0
// ----------------------------------------------------------------------------
module tb_jtkunio_pal_arb;

  logic       clk;
  logic       rst_n;
  logic       pxl_cen, vid_blank;
  logic [7:0] vid_a;
  logic [3:0] red, green, blue;
  logic       cpu_req, cpu_we;
  logic [8:0] cpu_addr;
  logic [7:0] cpu_din, cpu_dout;
  logic       cpu_ack, wbuf_full;
  logic [8:0] ram_addr;
  logic [7:0] ram_din, ram_q;
  logic       ram_we;

  jtkunio_pal_arb #(.AW(9), .SIMFILE("pal.bin")) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .vid_blank(vid_blank),
    .vid_a(vid_a), .red(red), .green(green), .blue(blue),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .wbuf_full(wbuf_full), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;

  logic [7:0] mem    [0:511];
  logic [7:0] shadow [0:511];
  bit         preloaded = 1'b0;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      'h005: return 8'h0A;
      'h105: return 8'h3C;
      'h012: return 8'hF7;
      'h112: return 8'h5E;
      'h07F: return 8'h31;
      'h17F: return 8'hA9;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  // palette RAM: one-cycle registered read
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
      preloaded <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_q <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] colour(input logic [7:0] idx);
    logic [7:0] lo, hi;
    lo = shadow[{1'b0, idx}];
    hi = shadow[{1'b1, idx}];
    return {hi[3:0], hi[7:4], lo[3:0]};
  endfunction

  // monitor: video slot addresses, no writes in video slots, colour latency
  bit         chk_vid = 1'b0;
  int         slot_m = 3;
  logic [7:0] cur_idx, prev_idx;
  logic       cur_blank, prev_blank;
  bit         have_prev = 1'b0, cmp_pend = 1'b0;
  logic [11:0] exp_rgb;

  always @(negedge clk) begin
    if (ram_we) wr_cnt++;
    if (cpu_ack) ack_cnt++;
    if (!rst_n) begin
      slot_m = 3; have_prev = 1'b0; cmp_pend = 1'b0;
    end else begin
      if (cmp_pend) begin
        chk("vid_rgb", 32'({red, green, blue}), 32'(exp_rgb));
        cmp_pend = 1'b0;
      end
      if (pxl_cen) begin
        if (chk_vid && have_prev) begin
          exp_rgb  = prev_blank ? 12'd0 : colour(prev_idx);
          cmp_pend = 1'b1;
        end
        have_prev  = chk_vid;
        prev_idx   = vid_a;
        prev_blank = vid_blank;
        slot_m     = 0;
        cur_idx    = vid_a;
        cur_blank  = vid_blank;
      end else if (slot_m < 3) begin
        slot_m++;
      end
      if (slot_m < 2 && !cur_blank) begin
        chk("vid_addr", 32'(ram_addr), 32'({(slot_m == 1), cur_idx}));
        chk("vid_no_we", 32'(ram_we), 32'd0);
      end
    end
  end

  bit pxl_auto = 1'b0;
  int pxl_cnt  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (pxl_auto) begin
      if (pxl_cnt == 0) begin
        pxl_cen   = 1'b1;
        vid_a     = 8'($urandom_range(0, 127));
        vid_blank = ($urandom_range(0, 3) == 0);
        pxl_cnt   = $urandom_range(2, 5);
      end else begin
        pxl_cen = 1'b0;
        pxl_cnt--;
      end
    end
  endtask

  task automatic wait_ack(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      cyc();
      #1;
      if (cpu_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  idx;
    logic        blank;
    logic [11:0] exp_rgb;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [6];
    bit         ok, we;
    logic [8:0] a;
    logic [7:0] d;
    int         ack_before, wr_before;

    tbl[0] = '{8'h05, 1'b0, 12'hC3A};
    tbl[1] = '{8'h05, 1'b0, 12'hC3A};
    tbl[2] = '{8'h12, 1'b1, 12'h000};
    tbl[3] = '{8'h12, 1'b0, 12'hE57};
    tbl[4] = '{8'h7F, 1'b0, 12'h9A1};
    tbl[5] = '{8'h05, 1'b0, 12'hC3A};
    for (int i = 0; i < 512; i++) shadow[i] = init_val(i);

    rst_n = 1'b0; pxl_cen = 1'b0; vid_blank = 1'b0; vid_a = 8'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 9'd0; cpu_din = 8'd0;
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_dout", 32'(cpu_dout), 32'd0);
    chk("rst_wbuf", 32'(wbuf_full), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    repeat (100) cyc();
    chk("idle_no_we", 32'(wr_cnt), 32'd0);
    chk("idle_rgb", 32'({red, green, blue}), 32'd0);

    // video table, pxl_cen every 4 clocks; colour shows after the next pxl_cen
    for (int i = 0; i <= 6; i++) begin
      pxl_cen   = 1'b1;
      vid_a     = (i < 6) ? tbl[i].idx : 8'h00;
      vid_blank = (i < 6) ? tbl[i].blank : 1'b1;
      cyc();
      pxl_cen = 1'b0;
      #1;
      if (i == 0) chk("tbl_first", 32'({red, green, blue}), 32'd0);
      else        chk("tbl_rgb", 32'({red, green, blue}), 32'(tbl[i-1].exp_rgb));
      repeat (3) cyc();
    end

    // blanked pixel: slot 0 becomes a CPU slot
    pxl_cen = 1'b1; vid_blank = 1'b1; vid_a = 8'h05;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
    #1;
    chk("b_rd_addr", 32'(ram_addr), 32'h005);
    cyc();
    pxl_cen = 1'b0;
    #1;
    chk("b_rd_ack", 32'(cpu_ack), 32'd1);
    chk("b_rd_data", 32'(cpu_dout), 32'h0A);
    chk("b_no_vhi", 32'(ram_addr), 32'd0);
    cpu_req = 1'b0;
    repeat (3) cyc();
    pxl_cen = 1'b1; vid_blank = 1'b0; vid_a = 8'h12;
    cyc();
    pxl_cen = 1'b0;
    #1;
    chk("b_rgb_blank", 32'({red, green, blue}), 32'd0);
    repeat (4) cyc();

    // write then immediate read of the same address
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h105; cpu_din = 8'h77;
    cyc();
    #1;
    chk("c_wr_ack", 32'(cpu_ack), 32'd1);
    chk("c_wbuf", 32'(wbuf_full), 32'd1);
    chk("c_drain_we", 32'(ram_we), 32'd1);
    chk("c_drain_addr", 32'(ram_addr), 32'h105);
    shadow[9'h105] = 8'h77;
    cpu_we = 1'b0;
    wait_ack(20, ok);
    chk("c_rd_ack", 32'(ok), 32'd1);
    chk("c_rd_data", 32'(cpu_dout), 32'h77);
    cpu_req = 1'b0;
    repeat (3) cyc();

    // back-to-back writes with video active: drains only in slot 2/3
    pxl_cen = 1'b1; vid_blank = 1'b0; vid_a = 8'h20;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h0C0; cpu_din = 8'h11;
    cyc();
    pxl_cen = 1'b0;
    #1;
    chk("d_ack1", 32'(cpu_ack), 32'd1);
    chk("d_wbuf1", 32'(wbuf_full), 32'd1);
    chk("d_we_slot1", 32'(ram_we), 32'd0);
    cpu_addr = 9'h1C0; cpu_din = 8'h22;
    cyc();
    #1;
    chk("d_drain1_we", 32'(ram_we), 32'd1);
    chk("d_drain1_addr", 32'(ram_addr), 32'h0C0);
    chk("d_drain1_din", 32'(ram_din), 32'h11);
    chk("d_ack2_wait", 32'(cpu_ack), 32'd0);
    cyc();
    pxl_cen = 1'b1; vid_a = 8'h21;
    #1;
    chk("d_ack2", 32'(cpu_ack), 32'd1);
    chk("d_wbuf_stays", 32'(wbuf_full), 32'd1);
    chk("d_we_slot0", 32'(ram_we), 32'd0);
    cpu_req = 1'b0;
    cyc();
    pxl_cen = 1'b0;
    #1;
    chk("d_we_slot1b", 32'(ram_we), 32'd0);
    cyc();
    #1;
    chk("d_drain2_addr", 32'(ram_addr), 32'h1C0);
    chk("d_drain2_we", 32'(ram_we), 32'd1);
    cyc();
    #1;
    chk("d_wbuf_clr", 32'(wbuf_full), 32'd0);
    shadow[9'h0C0] = 8'h11;
    shadow[9'h1C0] = 8'h22;
    repeat (3) cyc();

    // reset while the write buffer holds data and a second write waits
    wr_before = wr_cnt;
    pxl_cen = 1'b1; vid_blank = 1'b0; vid_a = 8'h30;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h0E0; cpu_din = 8'hAB;
    cyc();
    pxl_cen = 1'b0;
    #1;
    chk("f_wbuf", 32'(wbuf_full), 32'd1);
    cpu_addr = 9'h1E0; cpu_din = 8'hCD;
    rst_n = 1'b0;
    #1;
    ack_before = ack_cnt;
    chk("f_rst_wbuf", 32'(wbuf_full), 32'd0);
    chk("f_rst_ack", 32'(cpu_ack), 32'd0);
    chk("f_rst_we", 32'(ram_we), 32'd0);
    chk("f_rst_rgb", 32'({red, green, blue}), 32'd0);
    cpu_req = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    chk("f_no_ram_we", 32'(wr_cnt), 32'(wr_before));
    chk("f_no_ack", 32'(ack_cnt), 32'(ack_before));
    chk("f_mem_a", 32'(mem[9'h0E0]), 32'(shadow[9'h0E0]));
    chk("f_mem_b", 32'(mem[9'h1E0]), 32'(shadow[9'h1E0]));

    // randomized CPU traffic against live video; CPU writes avoid the
    // palette entries the video indices use so colours stay predictable
    chk_vid  = 1'b1;
    pxl_auto = 1'b1;
    pxl_cnt  = 0;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      if (we) a = {1'($urandom_range(0, 1)), 1'b1, 7'($urandom_range(0, 127))};
      else    a = 9'($urandom_range(0, 511));
      d = 8'($urandom);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
      wait_ack(40, ok);
      chk("rnd_ack", 32'(ok), 32'd1);
      if (ok) begin
        if (we) shadow[a] = d;
        else    chk("rnd_rd", 32'(cpu_dout), 32'(shadow[a]));
      end
      cpu_req = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
    end
    chk_vid  = 1'b0;
    pxl_auto = 1'b0;
    pxl_cen  = 1'b0;
    repeat (10) cyc();

    for (int i = 0; i < 512; i++)
      if (mem[i] !== shadow[i]) chk("final_mem", 32'(mem[i]), 32'(shadow[i]));
    chk("final_wbuf", 32'(wbuf_full), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtkunio_pal_arb.md
Name: jtkunio_pal_arb

Overview:
Time-slot arbiter that shares one single-port 512x8 palette RAM between the video colour lookup and the main CPU. For each pixel it issues two video reads, blue byte then green/red byte, and assembles a registered 12-bit colour. Remaining cycles serve CPU reads and posted CPU writes through a req/ack handshake. It sits between the colour-mix priority logic (which supplies the 8-bit palette index) and the palette RAM macro.

Parameters:
AW, 9, palette RAM address width; bit 8 selects the byte half.
SIMFILE, "pal.bin", passed through for simulation preload reference only; no RTL effect.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pxl_cen  in  1  pixel clock enable; spacing is at least 3 clk cycles
vid_blank  in  1  high = blanking (!LHBL or !LVBL), sampled on pxl_cen
vid_a  in  8  palette index from priority logic, sampled on pxl_cen
red  out  4  colour output
green  out  4  colour output
blue  out  4  colour output
cpu_req  in  1  CPU access request; level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  9  CPU palette address
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data, valid when cpu_ack follows a read
cpu_ack  out  1  one-cycle acknowledge pulse
wbuf_full  out  1  posted-write buffer occupied
ram_addr  out  9  RAM address
ram_din  out  8  RAM write data
ram_we  out  1  RAM write strobe
ram_q  in  8  RAM read data, valid 1 cycle after ram_addr

Behaviour:
- Reset values: red, green and blue = 0; cpu_ack = 0; cpu_dout = 0; wbuf_full = 0; ram_we = 0; ram_addr = 0. Slot counter = 3 (CPU slot). Internal nr/ng/nb = 0; no read is in flight.
- Slot counter: forced to 0 on the cycle pxl_cen = 1, then increments each clk and saturates at 3.
  - Slot 0 = VLO: issues ram_addr = {1'b0, vid_a}.
  - Slot 1 = VHI: issues {1'b1, vid_a latched at slot 0}.
  - Slots 2 and 3 = CPU.
- If vid_blank = 1 at pxl_cen: no video reads that pixel, and slots 0 and 1 also become CPU slots.
- Video capture:
  - Data from the VLO read arrives at slot 1; nb <= ram_q[3:0].
  - Data from the VHI read arrives at slot 2; {ng, nr} <= ram_q.
  - Upper nibble of the blue byte is ignored.
- Output update: on each pxl_cen, {red, green, blue} <= blank_latched ? 0 : {nr, ng, nb}. blank_latched is vid_blank as latched at the previous pxl_cen.
- Video latency: colour for the index sampled at pxl_cen N appears at the outputs the cycle after pxl_cen N+1.
- CPU write:
  - If the buffer is empty, latch addr/data, set wbuf_full, and pulse cpu_ack the next cycle.
  - If the buffer is full, no ack; cpu_req stays pending.
  - The buffer drains in the first free CPU slot: ram_we = 1 for exactly one cycle, then wbuf_full clears.
  - If the buffer drains and a new write is accepted in the same cycle, wbuf_full stays 1.
- CPU read:
  - Issued only in a CPU slot and only while wbuf_full = 0, so a read after a write always sees the written value.
  - Issue cycle T: ram_addr = cpu_addr. At T+1: cpu_dout <= ram_q and cpu_ack = 1 in cycle T+1.
  - Only one read is in flight at a time.
  - A pxl_cen arriving at T+1 does not disturb the read, because the port is pipelined.
- Priority within a CPU slot: buffer drain > CPU read.
- Request hold: the requester deasserts cpu_req the cycle after it sees cpu_ack. A request still held at ack is treated as new.
- pxl_cen spacing of 3: one CPU slot per active pixel. CPU starvation is bounded to one pixel period.
- Async reset asserted mid-operation:
  - The buffered write is discarded, with no RAM write.
  - A pending read gets no ack.
  - Outputs return to their reset values immediately.

Test Plan:
- Reset then idle: all outputs 0; wbuf_full = 0; no ram_we for 100 cycles.
- RAM preloaded [0x005] = 0x0A, [0x105] = 0x3C. vid_a = 5, vid_blank = 0, pxl_cen every 4 clk -> after the second pxl_cen: red = C, green = 3, blue = A.
- vid_blank = 1 at pxl_cen -> RGB = 0 at the next pxl_cen; no video addresses issued; a CPU read in slot 0 acks at T+1.
- CPU write 0x105 <= 0x77 then an immediate read of 0x105 -> write acked at the next cycle; read waits for drain and returns 0x77.
- Two back-to-back writes while pxl_cen is active -> second ack delayed until the first drains in a slot 2 or 3; ram_we never in slot 0 or 1.
- rst_n pulsed low while wbuf_full = 1 -> RAM content unchanged; cpu_ack never pulses for the discarded write.
